// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared widths, sequencer state encoding and ALU opcode names.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam int c_DATA_W = 8;
    localparam int c_OP_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } seq_state_e;

    // Opcode map understood by alu_8bit
    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADC  = 4'h1,
        OP_SUB  = 4'h2,
        OP_SBC  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_NOT  = 4'h7,
        OP_SHL  = 4'h8,
        OP_SHR  = 4'h9,
        OP_ROL  = 4'hA,
        OP_ROR  = 4'hB,
        OP_INC  = 4'hC,
        OP_DEC  = 4'hD,
        OP_PASS = 4'hE,
        OP_CMP  = 4'hF
    } alu_op_e;

endpackage
`default_nettype wire

// File: rtl/alu_settle_counter.sv
`default_nettype none
// ============================================================================
// Module   : alu_settle_counter
// Brief    : Loadable down-counter that reloads to SETTLE and flags zero.
// Revision : 1.0
// ============================================================================
module alu_settle_counter #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= CW'(SETTLE);
        end else if (dec) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Sweeps an external ALU over an opcode range for one operand pair
//            and streams each captured result/carry over valid/ready.
// Revision : 1.0
// ============================================================================
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int OP_W   = c_OP_W,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [DATA_W-1:0] start_a,
    input  logic [DATA_W-1:0] start_b,
    input  logic [OP_W-1:0]   op_first,
    input  logic [OP_W-1:0]   op_last,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_carry,
    input  logic [DATA_W-1:0] alu_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OP_W-1:0]   res_opcode,
    output logic [DATA_W-1:0] res_result,
    output logic [DATA_W-1:0] res_carry,
    output logic              res_last,
    output logic              done,
    output logic              err_range
);

    seq_state_e        r_state;
    logic [OP_W-1:0]   r_op_last;

    logic w_accept;
    logic w_advance;
    logic w_cnt_dec;
    logic w_cnt_zero;

    assign start_ready = (r_state == ST_IDLE);
    assign w_accept    = start_ready && start_valid && (op_last >= op_first);
    assign w_advance   = (r_state == ST_HOLD) && res_ready && !res_last;
    assign w_cnt_dec   = (r_state == ST_SETTLE) && !w_cnt_zero;

    alu_settle_counter #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_accept || w_advance),
        .dec   (w_cnt_dec),
        .zero  (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_op_last  <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            res_valid  <= 1'b0;
            res_opcode <= '0;
            res_result <= '0;
            res_carry  <= '0;
            res_last   <= 1'b0;
            done       <= 1'b0;
            err_range  <= 1'b0;
        end else begin
            done      <= 1'b0;
            err_range <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        alu_a      <= start_a;
                        alu_b      <= start_b;
                        alu_opcode <= op_first;
                        r_op_last  <= op_last;
                        r_state    <= ST_SETTLE;
                    end else if (start_valid) begin
                        err_range  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (w_cnt_zero) begin
                        res_result <= alu_result;
                        res_carry  <= alu_carry;
                        res_opcode <= alu_opcode;
                        res_last   <= (alu_opcode == r_op_last);
                        res_valid  <= 1'b1;
                        r_state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // The last opcode terminates on equality, so the
                    // increment never wraps past the top of the range.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (res_last) begin
                            done    <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            alu_opcode <= alu_opcode + OP_W'(1);
                            r_state    <= ST_SETTLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
